regfile_wb_arbiter: RTL and testbench

Write-port controller for the 32x32 register file. It arbitrates two writeback requesters onto the single regfile write port (rd_wren/rd_addr/rd_data): A is the ALU/EX path and B is the load/MEM path. Arbitration is fixed-priority with starvation relief, over valid/ready handshakes. A clear sequencer zeroes x1..x31 on request. All write-port outputs are registered; the block sits between the pipeline writeback stage and the regfile.

---
 rtl/regfile_wb_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: requesters A (EX) and B (MEM) share one write port; B has priority unless A is starved. Also runs a clear sequence that zeroes x1..x31.
// Latency: 1 cycle from a handshake to rd_wren_o/rd_addr_o/rd_data_o.
// Backpressure: the readies are combinational grants; both are held low during reset, on a clear request and for the whole clear sequence.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_valid_i,
    output logic              a_ready_o,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_data_i,
    input  logic              b_valid_i,
    output logic              b_ready_o,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_data_i,
    input  logic              clr_req_i,
    output logic              busy_o,
    output logic              rd_wren_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] LAST_REG   = '1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0]  starve, starve_nxt;
    logic              a_grant, b_grant;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            ptr    <= '0;
            starve <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            starve <= starve_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        starve_nxt = starve;
        a_grant    = 1'b0;
        b_grant    = 1'b0;
        case (state)
            IDLE: begin
                if (!rst_i && !clr_req_i) begin
                    if (a_valid_i && b_valid_i) begin
                        if (starve == STARVE_LIM) a_grant = 1'b1;
                        else                      b_grant = 1'b1;
                    end else if (a_valid_i) begin
                        a_grant = 1'b1;
                    end else if (b_valid_i) begin
                        b_grant = 1'b1;
                    end
                end
                if (clr_req_i) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = ADDR_W'(1);
                end
                // A denied while asking counts toward starvation relief, including on a clear request
                if (a_valid_i && !a_grant)
                    starve_nxt = (starve == STARVE_LIM) ? starve : starve + CNT_W'(1);
                else
                    starve_nxt = '0;
            end
            CLEAR: begin
                ptr_nxt = ptr + ADDR_W'(1);
                if (ptr == LAST_REG) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign a_ready_o = a_grant;
    assign b_ready_o = b_grant;
    assign busy_o    = (state == CLEAR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_wren_o <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
        end else if (state == CLEAR) begin
            rd_wren_o <= 1'b1;
            rd_addr_o <= ptr;
            rd_data_o <= '0;
        end else if (a_grant) begin
            rd_wren_o <= (a_addr_i != '0);
            rd_addr_o <= a_addr_i;
            rd_data_o <= a_data_i;
        end else if (b_grant) begin
            rd_wren_o <= (b_addr_i != '0);
            rd_addr_o <= b_addr_i;
            rd_data_o <= b_data_i;
        end else begin
            rd_wren_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a per-cycle vector table, then hand-written clear sequences.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_ready, b_valid, b_ready, clr_req, busy, rd_wren;
    logic [4:0]  a_addr, b_addr, rd_addr;
    logic [31:0] a_data, b_data, rd_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_addr_i(a_addr), .a_data_i(a_data),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_addr_i(b_addr), .b_data_i(b_data),
        .clr_req_i(clr_req), .busy_o(busy),
        .rd_wren_o(rd_wren), .rd_addr_o(rd_addr), .rd_data_o(rd_data)
    );

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        ar;
        logic        br;
        logic        wren;
        logic [4:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                                input logic ar, input logic br, input logic wren,
                                input logic [4:0] addr, input logic [31:0] data);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
        v.ar = ar; v.br = br; v.wren = wren; v.addr = addr; v.data = data;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                         input logic clr);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        clr_req = clr;
    endtask

    initial begin
        // Each row is one cycle: inputs for this cycle, expected readies now, and
        // expected write-port outputs resulting from the previous cycle.
        vecs[0]  = mk(1, 7,  32'hA7,       1, 9,  32'hB9,       0, 1, 0, 0,  32'h0);
        vecs[1]  = mk(0, 0,  0,            0, 0,  0,            0, 0, 1, 9,  32'hB9);
        vecs[2]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0,            1, 0, 0, 9,  32'hB9);
        vecs[3]  = mk(0, 0,  0,            0, 0,  0,            0, 0, 1, 5,  32'hDEADBEEF);
        vecs[4]  = mk(0, 0,  0,            0, 0,  0,            0, 0, 0, 5,  32'hDEADBEEF);
        vecs[5]  = mk(1, 3,  32'h11,       1, 4,  32'h22,       0, 1, 0, 5,  32'hDEADBEEF);
        vecs[6]  = mk(1, 3,  32'h11,       0, 0,  0,            1, 0, 1, 4,  32'h22);
        vecs[7]  = mk(0, 0,  0,            0, 0,  0,            0, 0, 1, 3,  32'h11);
        vecs[8]  = mk(0, 0,  0,            1, 0,  32'hFFFFFFFF, 0, 1, 0, 3,  32'h11);
        vecs[9]  = mk(0, 0,  0,            0, 0,  0,            0, 0, 0, 0,  32'hFFFFFFFF);
        vecs[10] = mk(1, 10, 32'hAAAA,     1, 11, 32'hB0,       0, 1, 0, 0,  32'hFFFFFFFF);
        vecs[11] = mk(1, 10, 32'hAAAA,     1, 12, 32'hB1,       0, 1, 1, 11, 32'hB0);
        vecs[12] = mk(1, 10, 32'hAAAA,     1, 13, 32'hB2,       0, 1, 1, 12, 32'hB1);
        vecs[13] = mk(1, 10, 32'hAAAA,     1, 14, 32'hB3,       0, 1, 1, 13, 32'hB2);
        vecs[14] = mk(1, 10, 32'hAAAA,     1, 15, 32'hB4,       1, 0, 1, 14, 32'hB3);
        vecs[15] = mk(1, 10, 32'hAAAB,     1, 15, 32'hB4,       0, 1, 1, 10, 32'hAAAA);
        vecs[16] = mk(1, 10, 32'hAAAB,     0, 0,  0,            1, 0, 1, 15, 32'hB4);
        vecs[17] = mk(0, 0,  0,            0, 0,  0,            0, 0, 1, 10, 32'hAAAB);
        vecs[18] = mk(0, 0,  0,            0, 0,  0,            0, 0, 0, 10, 32'hAAAB);

        // Reset held with both requesters asking
        rst = 1'b1;
        drive(1, 7, 32'hA7, 1, 9, 32'hB9, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst a_ready", {31'b0, a_ready}, 32'd0);
        chk("rst b_ready", {31'b0, b_ready}, 32'd0);
        chk("rst busy",    {31'b0, busy},    32'd0);
        chk("rst wren",    {31'b0, rd_wren}, 32'd0);
        chk("rst addr",    {27'b0, rd_addr}, 32'd0);
        chk("rst data",    rd_data,          32'd0);

        for (int i = 0; i < 19; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd, 0);
            @(negedge clk);
            chk($sformatf("row%0d a_ready", i), {31'b0, a_ready}, {31'b0, vecs[i].ar});
            chk($sformatf("row%0d b_ready", i), {31'b0, b_ready}, {31'b0, vecs[i].br});
            chk($sformatf("row%0d busy", i),    {31'b0, busy},    32'd0);
            chk($sformatf("row%0d wren", i),    {31'b0, rd_wren}, {31'b0, vecs[i].wren});
            chk($sformatf("row%0d addr", i),    {27'b0, rd_addr}, {27'b0, vecs[i].addr});
            chk($sformatf("row%0d data", i),    rd_data,          vecs[i].data);
        end

        // Clear pulse at T with A pending; A and B stay valid throughout
        @(posedge clk);
        #1;
        drive(1, 20, 32'h55, 1, 21, 32'h66, 1);
        @(negedge clk);
        chk("clrT a_ready", {31'b0, a_ready}, 32'd0);
        chk("clrT b_ready", {31'b0, b_ready}, 32'd0);
        chk("clrT busy",    {31'b0, busy},    32'd0);
        for (int c = 1; c <= 32; c++) begin
            @(posedge clk);
            #1;
            // a second request mid-clear must be ignored
            drive(1, 20, 32'h55, 0, 0, 0, (c == 5));
            @(negedge clk);
            chk($sformatf("clr T+%0d busy", c),    {31'b0, busy},    {31'b0, (c <= 31)});
            chk($sformatf("clr T+%0d a_ready", c), {31'b0, a_ready}, {31'b0, (c == 32)});
            if (c == 1) begin
                chk("clr T+1 wren", {31'b0, rd_wren}, 32'd0);
            end else begin
                chk($sformatf("clr T+%0d wren", c), {31'b0, rd_wren}, 32'd1);
                chk($sformatf("clr T+%0d addr", c), {27'b0, rd_addr}, c - 1);
                chk($sformatf("clr T+%0d data", c), rd_data,          32'd0);
            end
        end
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post-clr A wren", {31'b0, rd_wren}, 32'd1);
        chk("post-clr A addr", {27'b0, rd_addr}, 32'd20);
        chk("post-clr A data", rd_data,          32'h55);

        // Clear interrupted by reset at T+10
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            drive(0, 0, 0, 0, 0, 0, 0);
            rst = (c == 10);
            @(negedge clk);
            if (c == 10) begin
                chk("rstclr T+10 busy", {31'b0, busy},    32'd1);
                chk("rstclr T+10 wren", {31'b0, rd_wren}, 32'd1);
                chk("rstclr T+10 addr", {27'b0, rd_addr}, 32'd9);
            end else if (c >= 11) begin
                chk($sformatf("rstclr T+%0d busy", c), {31'b0, busy},    32'd0);
                chk($sformatf("rstclr T+%0d wren", c), {31'b0, rd_wren}, 32'd0);
                if (c == 11) chk("rstclr T+11 addr", {27'b0, rd_addr}, 32'd0);
            end
        end

        // Port usable again after the aborted clear
        @(posedge clk);
        #1;
        drive(0, 0, 0, 1, 6, 32'h1234, 0);
        @(negedge clk);
        chk("after rst b_ready", {31'b0, b_ready}, 32'd1);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("after rst wren", {31'b0, rd_wren}, 32'd1);
        chk("after rst addr", {27'b0, rd_addr}, 32'd6);
        chk("after rst data", rd_data,          32'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
